// File: rtl/sram_rr_arbiter_if.sv
// Command/response bundle between two requesters, the arbiter and one single-port SRAM.
// slave = arbiter side, master = requester/SRAM side.
interface sram_rr_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
);
  localparam int AW = $clog2(DEPTH);

  logic             req0_valid;
  logic             req0_ready;
  logic             req0_we;
  logic [AW-1:0]    req0_addr;
  logic [WIDTH-1:0] req0_wdata;
  logic             req0_rvalid;
  logic [WIDTH-1:0] req0_rdata;

  logic             req1_valid;
  logic             req1_ready;
  logic             req1_we;
  logic [AW-1:0]    req1_addr;
  logic [WIDTH-1:0] req1_wdata;
  logic             req1_rvalid;
  logic [WIDTH-1:0] req1_rdata;

  logic             sram_ren;
  logic             sram_wen;
  logic [AW-1:0]    sram_addr;
  logic [WIDTH-1:0] sram_d;
  logic [WIDTH-1:0] sram_q;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    output req0_ready, req0_rvalid, req0_rdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req1_ready, req1_rvalid, req1_rdata,
    output sram_ren, sram_wen, sram_addr, sram_d,
    input  sram_q
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    input  req0_ready, req0_rvalid, req0_rdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req1_ready, req1_rvalid, req1_rdata,
    input  sram_ren, sram_wen, sram_addr, sram_d,
    output sram_q
  );
endinterface

// File: rtl/sram_rr_arbiter.sv
// Two-port round-robin (or fixed-priority) front end for a single-port SRAM; grant is same-cycle,
// read data returns READ_LATENCY cycles after accept; losers are held off via ready, returns have no backpressure.
module sram_rr_arbiter #(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 32,
  parameter int READ_LATENCY   = 1,
  parameter int FIXED_PRIORITY = 0
) (
  input logic              clk,
  input logic              rst,
  sram_rr_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic                    last;
  logic                    gnt0;
  logic                    gnt1;
  logic                    xfer;
  logic                    sel_we;
  logic [AW-1:0]           sel_addr;
  logic [WIDTH-1:0]        sel_wdata;
  logic [AW-1:0]           held_addr;
  logic [WIDTH-1:0]        held_d;
  logic                    push_vld;
  logic [READ_LATENCY-1:0] pipe_vld;
  logic [READ_LATENCY-1:0] pipe_id;

  // A collision goes to the port that did not win the previous transfer.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if (FIXED_PRIORITY != 0 || last) gnt0 = 1'b1;
        else                             gnt1 = 1'b1;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  assign xfer      = gnt0 | gnt1;
  assign sel_we    = gnt1 ? bus.req1_we    : bus.req0_we;
  assign sel_addr  = gnt1 ? bus.req1_addr  : bus.req0_addr;
  assign sel_wdata = gnt1 ? bus.req1_wdata : bus.req0_wdata;
  assign push_vld  = xfer & ~sel_we;

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  assign bus.sram_ren  = xfer & ~sel_we;
  assign bus.sram_wen  = xfer & sel_we;
  assign bus.sram_addr = rst ? '0 : (xfer ? sel_addr  : held_addr);
  assign bus.sram_d    = rst ? '0 : (xfer ? sel_wdata : held_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      last      <= 1'b1;
      held_addr <= '0;
      held_d    <= '0;
    end else if (xfer) begin
      last      <= gnt1;
      held_addr <= sel_addr;
      held_d    <= sel_wdata;
    end
  end

  // Tag pipeline mirrors the SRAM read latency so each return finds its owner.
  if (READ_LATENCY == 1) begin : g_pipe1
    always_ff @(posedge clk) begin
      if (rst) begin
        pipe_vld <= '0;
        pipe_id  <= '0;
      end else begin
        pipe_vld <= push_vld;
        pipe_id  <= gnt1;
      end
    end
  end else begin : g_pipen
    always_ff @(posedge clk) begin
      if (rst) begin
        pipe_vld <= '0;
        pipe_id  <= '0;
      end else begin
        pipe_vld <= {pipe_vld[READ_LATENCY-2:0], push_vld};
        pipe_id  <= {pipe_id[READ_LATENCY-2:0], gnt1};
      end
    end
  end

  assign bus.req0_rvalid = ~rst & pipe_vld[READ_LATENCY-1] & ~pipe_id[READ_LATENCY-1];
  assign bus.req1_rvalid = ~rst & pipe_vld[READ_LATENCY-1] &  pipe_id[READ_LATENCY-1];
  assign bus.req0_rdata  = bus.sram_q;
  assign bus.req1_rdata  = bus.sram_q;
endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench: four arbiter configurations, each with a behavioural SRAM, a vector table for grants
// and a per-instance return scoreboard.
module tb_sram_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          due;
  } sb_t;

  typedef struct {
    int          inst;
    logic        v0;
    logic        we0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic        we1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        r0;
    logic        r1;
  } vec_t;

  vec_t tv[$];

  logic        v0[4], we0[4], v1[4], we1[4];
  logic [4:0]  a0[4], a1[4];
  logic [31:0] d0[4], d1[4];
  logic        rdy0[4], rdy1[4], rv0[4], rv1[4], ren[4], wen[4];
  logic [31:0] rd0[4], rd1[4], sd[4];
  logic [4:0]  saddr[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_drives();
    for (int i = 0; i < 4; i++) begin
      v0[i] = 1'b0; we0[i] = 1'b0; a0[i] = 5'd0; d0[i] = 32'd0;
      v1[i] = 1'b0; we1[i] = 1'b0; a1[i] = 5'd0; d1[i] = 32'd0;
    end
  endtask

  task automatic addv(input int inst,
                      input logic v0_, input logic we0_, input logic [4:0] a0_, input logic [31:0] d0_,
                      input logic v1_, input logic we1_, input logic [4:0] a1_, input logic [31:0] d1_,
                      input logic r0_, input logic r1_);
    vec_t t;
    t.inst = inst;
    t.v0 = v0_; t.we0 = we0_; t.a0 = a0_; t.d0 = d0_;
    t.v1 = v1_; t.we1 = we1_; t.a1 = a1_; t.d1 = d1_;
    t.r0 = r0_; t.r1 = r1_;
    tv.push_back(t);
  endtask

  for (genvar g = 0; g < 4; g++) begin : u
    localparam int RL = (g == 2) ? 3 : ((g == 3) ? 2 : 1);
    localparam int FP = (g == 1) ? 1 : 0;

    sram_rr_arbiter_if #(.WIDTH(32), .DEPTH(32)) bus();

    sram_rr_arbiter #(.WIDTH(32), .DEPTH(32), .READ_LATENCY(RL), .FIXED_PRIORITY(FP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign bus.req0_valid = v0[g];
    assign bus.req0_we    = we0[g];
    assign bus.req0_addr  = a0[g];
    assign bus.req0_wdata = d0[g];
    assign bus.req1_valid = v1[g];
    assign bus.req1_we    = we1[g];
    assign bus.req1_addr  = a1[g];
    assign bus.req1_wdata = d1[g];
    assign rdy0[g]  = bus.req0_ready;
    assign rdy1[g]  = bus.req1_ready;
    assign rv0[g]   = bus.req0_rvalid;
    assign rv1[g]   = bus.req1_rvalid;
    assign rd0[g]   = bus.req0_rdata;
    assign rd1[g]   = bus.req1_rdata;
    assign ren[g]   = bus.sram_ren;
    assign wen[g]   = bus.sram_wen;
    assign saddr[g] = bus.sram_addr;
    assign sd[g]    = bus.sram_d;

    // Behavioural single-port SRAM with RL-cycle read latency.
    logic [31:0] mem [32];
    logic [31:0] qp  [RL];
    always @(posedge clk) begin
      if (bus.sram_wen) mem[bus.sram_addr] <= bus.sram_d;
      qp[0] <= mem[bus.sram_addr];
      for (int i = 1; i < RL; i++) qp[i] <= qp[i-1];
    end
    assign bus.sram_q = qp[RL-1];

    sb_t         sbq[$];
    logic [31:0] shadow [32];
    logic [4:0]  held_a;
    logic [31:0] held_d;

    always @(negedge clk) begin : mon
      sb_t         e;
      logic        we;
      logic [4:0]  ad;
      logic [31:0] dd;
      if (rst) begin
        sbq.delete();
        held_a = 5'd0;
        held_d = 32'd0;
        chk($sformatf("u%0d_rst_outputs", g),
            64'({rdy0[g], rdy1[g], ren[g], wen[g], rv0[g], rv1[g], saddr[g], sd[g]}), 64'(0));
      end else begin
        if (rv0[g] || rv1[g]) begin
          if (sbq.size() == 0) begin
            chk($sformatf("u%0d_rvalid_unexpected", g), 64'({rv1[g], rv0[g]}), 64'(0));
          end else begin
            e = sbq.pop_front();
            chk($sformatf("u%0d_rvalid_port", g), 64'({rv1[g], rv0[g]}), 64'(e.port ? 2'b10 : 2'b01));
            chk($sformatf("u%0d_rvalid_cycle", g), 64'(cyc), 64'(e.due));
            chk($sformatf("u%0d_rdata", g), 64'(e.port ? rd1[g] : rd0[g]), 64'(e.data));
          end
        end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
          e = sbq.pop_front();
          chk($sformatf("u%0d_rvalid_missing", g), 64'({rv1[g], rv0[g]}), 64'(e.port ? 2'b10 : 2'b01));
        end
        chk($sformatf("u%0d_ready_legal", g),
            64'({rdy0[g] & rdy1[g], (rdy0[g] & ~v0[g]) | (rdy1[g] & ~v1[g])}), 64'(0));
        if ((v0[g] && rdy0[g]) || (v1[g] && rdy1[g])) begin
          we = rdy1[g] ? we1[g] : we0[g];
          ad = rdy1[g] ? a1[g]  : a0[g];
          dd = rdy1[g] ? d1[g]  : d0[g];
          chk($sformatf("u%0d_sram_drive", g),
              64'({ren[g], wen[g], saddr[g], sd[g]}), 64'({~we, we, ad, dd}));
          held_a = ad;
          held_d = dd;
          if (we) begin
            shadow[ad] = dd;
          end else begin
            e.port = rdy1[g];
            e.data = shadow[ad];
            e.due  = cyc + RL;
            sbq.push_back(e);
          end
        end else begin
          chk($sformatf("u%0d_sram_idle", g),
              64'({ren[g], wen[g], saddr[g], sd[g]}), 64'({1'b0, 1'b0, held_a, held_d}));
        end
      end
    end
  end

  initial begin
    clear_drives();
    // u0: RL=1 round robin. Collision right after reset goes to port 0.
    addv(0, 1'b1, 1'b1, 5'd7, 32'h11111111, 1'b1, 1'b1, 5'd8, 32'h22222222, 1'b1, 1'b0);
    addv(0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 5'd8, 32'h22222222, 1'b0, 1'b1);
    addv(0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0);
    addv(0, 1'b1, 1'b0, 5'd5, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0);
    addv(0, 1'b1, 1'b1, 5'd1, 32'hA1A1A1A1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0);
    addv(0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 5'd2, 32'hB2B2B2B2, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++)
      addv(0, 1'b1, 1'b0, 5'd1, 32'h0, 1'b1, 1'b0, 5'd2, 32'h0, (k % 2) == 0, (k % 2) == 1);
    // u1: fixed priority, port 1 waits until port 0 drops valid.
    addv(1, 1'b1, 1'b1, 5'd3, 32'h33333333, 1'b1, 1'b1, 5'd4, 32'h44444444, 1'b1, 1'b0);
    addv(1, 1'b1, 1'b1, 5'd9, 32'h99999999, 1'b1, 1'b1, 5'd4, 32'h44444444, 1'b1, 1'b0);
    addv(1, 1'b1, 1'b0, 5'd3, 32'h0,        1'b1, 1'b1, 5'd4, 32'h44444444, 1'b1, 1'b0);
    addv(1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 5'd4, 32'h44444444, 1'b0, 1'b1);
    addv(1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd4, 32'h0,        1'b0, 1'b1);
    // u2: RL=3, port 1 fills 0..3 then reads them back-to-back.
    for (int k = 0; k < 4; k++)
      addv(2, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'(k), 32'hC0C0C000 + 32'(k), 1'b0, 1'b1);
    for (int k = 0; k < 4; k++)
      addv(2, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'(k), 32'h0, 1'b0, 1'b1);
    // u3: RL=2 normal read before the reset sequence.
    addv(3, 1'b1, 1'b1, 5'd6, 32'h66666666, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    addv(3, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd6, 32'h0, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < tv.size(); k++) begin
      clear_drives();
      v0[tv[k].inst] = tv[k].v0; we0[tv[k].inst] = tv[k].we0;
      a0[tv[k].inst] = tv[k].a0; d0[tv[k].inst]  = tv[k].d0;
      v1[tv[k].inst] = tv[k].v1; we1[tv[k].inst] = tv[k].we1;
      a1[tv[k].inst] = tv[k].a1; d1[tv[k].inst]  = tv[k].d1;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", k), 64'({rdy0[tv[k].inst], rdy1[tv[k].inst]}),
          64'({tv[k].r0, tv[k].r1}));
      @(posedge clk);
      #1;
    end
    clear_drives();
    repeat (6) @(posedge clk);
    #1;

    // Reset with a read in flight on u3: the read must never come back.
    v0[3] = 1'b1; we0[3] = 1'b0; a0[3] = 5'd6;
    @(negedge clk);
    chk("rstseq_accept", 64'(rdy0[3]), 64'(1));
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rstseq_ready_in_rst", 64'({rdy0[3], rdy1[3], ren[3], wen[3]}), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    v0[3] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rstseq_no_rvalid", 64'({rv0[3], rv1[3]}), 64'(0));
      @(posedge clk);
      #1;
    end

    chk("u0_drained", 64'(u[0].sbq.size()), 64'(0));
    chk("u1_drained", 64'(u[1].sbq.size()), 64'(0));
    chk("u2_drained", 64'(u[2].sbq.size()), 64'(0));
    chk("u3_drained", 64'(u[3].sbq.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
